bbox_detect: RTL and testbench
==============================

# bbox_detect

Per-frame bounding-box finder for the binarised video path. It scans the black/white pixel stream in raster order and tracks the extent of foreground (black) pixels. At end of frame it produces the packed row/column bounds consumed directly by the rectangle overlay stage. Those bounds are padded by a margin and clamped so the overlay's ±1/±3/+4 line arithmetic never wraps.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- MARGIN, 4, padding added on every side of the detected box
- MIN_PIX, 16, minimum foreground pixel count for a valid detection
- FG_LEVEL, 10'd0, pixel value treated as foreground

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- en  in  1  pixel valid; Row/Col/iBW sampled only when high
- Row  in  10  raster row of current pixel
- Col  in  10  raster column of current pixel
- iBW  in  10  binarised pixel (0 or 10'h3FF)
- oRow  out  20  {bottom[19:10], top[9:0]} of padded box
- oCol  out  20  {right[19:10], left[9:0]} of padded box
- oValid  out  1  one-cycle pulse when oRow/oCol/oFound update
- oFound  out  1  last completed frame met MIN_PIX

## Operation
- Frame start (SOF): en && Row==0 && Col==0. Frame end (EOF): en && Row==V_ACTIVE-1 && Col==H_ACTIVE-1.
- Foreground pixel: en && iBW==FG_LEVEL.
- Accumulators: rmin, rmax, cmin, cmax (10 bit), cnt (19 bit, saturating at all-ones).
- Init values: rmin = cmin = 10'h3FF, rmax = cmax = 0, cnt = 0.
- SOF initialises the accumulators, then folds in the SOF pixel itself if it is foreground.
- Foreground pixel update: rmin = min(rmin, Row), rmax = max(rmax, Row), cmin = min(cmin, Col), cmax = max(cmax, Col), cnt += 1.
- FSM states:
  - IDLE: wait for SOF; all pixels ignored.
  - ACCUM: accumulate pixels. On EOF (last pixel included) go to LATCH. A SOF seen in ACCUM restarts accumulation; the partial frame is discarded and no oValid is produced.
  - LATCH: one cycle. Outputs are computed, oValid=1, then go to IDLE. If SOF arrives in this cycle, go to ACCUM with re-initialised accumulators; the latched result is not affected.
- Output computation in LATCH, using 11-bit intermediates to avoid wrap:
  - top = max(rmin − MARGIN, 0)
  - bottom = min(rmax + MARGIN, V_ACTIVE−1)
  - left = max(cmin − MARGIN, 1)
  - right = min(cmax + MARGIN, H_ACTIVE−5)
- If cnt < MIN_PIX: oFound=0 and oRow/oCol hold their previous values; oValid still pulses.
- If cnt ≥ MIN_PIX: oFound=1 and oRow/oCol are updated.
- en low in any state: hold all state; no counting.

## Timing
- Reset (async, rst low): oRow=0, oCol=0, oValid=0, oFound=0, FSM=IDLE, accumulators at init values. Reset mid-frame drops the frame; after release, the block waits for the next SOF.
- Latency: EOF sampled at edge E0. Outputs and oValid are valid after edge E1. oValid falls after E2.
- oRow/oCol/oFound are stable from E1 until the next LATCH. The overlay may sample them at any time.
- No backpressure; the block accepts one pixel per cycle whenever en=1.
- Non-raster order is not checked. Min/max remain correct for any order between SOF and EOF.

## Test plan
- Black block rows 100–149, cols 200–259, rest white, MIN_PIX=16 -> one oValid pulse 2 cycles after EOF; oRow={10'd153,10'd96}, oCol={10'd263,10'd196}, oFound=1.
- All-white frame after the previous case -> oValid pulses, oFound=0, oRow/oCol unchanged at {153,96}/{263,196}.
- Block at rows 0–9, cols 0–9 and a single pixel at (479,639) -> top=0, left=1, bottom=479, right=635.
- 8 foreground pixels only (< MIN_PIX) -> oFound=0, outputs held.
- SOF reinjected mid-frame (partial frame with a block at row 300, then a full frame with a block at rows 100–149) -> exactly one oValid, box reflects only the second frame.
- rst asserted at row 200 of a frame, released; then a full frame -> outputs zero during/after reset, no oValid for the aborted frame, correct box after the next full frame.
- Random en gaps (30% low) over the first test's frame -> results identical to the first test.

Source files
------------

// File: rtl/bbox_detect.sv
// bbox_detect: per-frame bounding box of foreground pixels in a binarised
// raster stream. At end of frame the box is padded by MARGIN, clamped so the
// downstream rectangle overlay never wraps, and presented with a one-cycle
// oValid strobe.
//
// Ports
//   clk     pixel clock, rising edge
//   rst     asynchronous reset, active low
//   en      pixel valid; Row/Col/iBW are ignored while low
//   Row     raster row of the current pixel
//   Col     raster column of the current pixel
//   iBW     binarised pixel (0 or 10'h3FF)
//   oRow    {bottom, top} of the padded box
//   oCol    {right, left} of the padded box
//   oValid  one-cycle pulse when oRow/oCol/oFound are refreshed
//   oFound  last completed frame had at least MIN_PIX foreground pixels
//
// state   | meaning
// S_IDLE  | waiting for start of frame, pixels ignored
// S_ACCUM | folding foreground pixels into the running extent
// S_LATCH | one cycle: pad/clamp the extent and publish it

module bbox_detect #(
   parameter int         H_ACTIVE = 640,
   parameter int         V_ACTIVE = 480,
   parameter int         MARGIN   = 4,
   parameter int         MIN_PIX  = 16,
   parameter logic [9:0] FG_LEVEL = 10'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [9:0]  Row,
   input  logic [9:0]  Col,
   input  logic [9:0]  iBW,
   output logic [19:0] oRow,
   output logic [19:0] oCol,
   output logic        oValid,
   output logic        oFound
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  rmin_q, rmin_d, rmax_q, rmax_d;
   logic [9:0]  cmin_q, cmin_d, cmax_q, cmax_d;
   logic [18:0] cnt_q, cnt_d;
   logic [19:0] o_row_q, o_row_d, o_col_q, o_col_d;
   logic        o_valid_q, o_valid_d, o_found_q, o_found_d;

   logic        sof, eof, fg;
   logic        do_init, do_fold;
   logic [9:0]  rmin_b, rmax_b, cmin_b, cmax_b;
   logic [18:0] cnt_b;

   logic [10:0] rmin_x, cmin_x, bot_sum, rgt_sum;
   logic [9:0]  top_v, bot_v, lft_v, rgt_v;
   logic        found;

   assign sof = en && (Row == 10'd0) && (Col == 10'd0);
   assign eof = en && (Row == 10'(V_ACTIVE - 1)) && (Col == 10'(H_ACTIVE - 1));
   assign fg  = en && (iBW == FG_LEVEL);

   // 11-bit intermediates keep the margin arithmetic from wrapping before the clamp.
   assign rmin_x  = {1'b0, rmin_q};
   assign cmin_x  = {1'b0, cmin_q};
   assign bot_sum = {1'b0, rmax_q} + 11'(MARGIN);
   assign rgt_sum = {1'b0, cmax_q} + 11'(MARGIN);

   assign top_v = (rmin_x >= 11'(MARGIN))     ? 10'(rmin_x - 11'(MARGIN)) : 10'd0;
   assign lft_v = (cmin_x >= 11'(MARGIN + 1)) ? 10'(cmin_x - 11'(MARGIN)) : 10'd1;
   assign bot_v = (bot_sum > 11'(V_ACTIVE - 1)) ? 10'(V_ACTIVE - 1) : bot_sum[9:0];
   assign rgt_v = (rgt_sum > 11'(H_ACTIVE - 5)) ? 10'(H_ACTIVE - 5) : rgt_sum[9:0];

   assign found = (cnt_q >= 19'(MIN_PIX));

   always_comb begin
      state_d   = state_q;
      rmin_d    = rmin_q;
      rmax_d    = rmax_q;
      cmin_d    = cmin_q;
      cmax_d    = cmax_q;
      cnt_d     = cnt_q;
      o_row_d   = o_row_q;
      o_col_d   = o_col_q;
      o_found_d = o_found_q;
      o_valid_d = 1'b0;
      do_init   = 1'b0;
      do_fold   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sof) begin
               state_d = S_ACCUM;
               do_init = 1'b1;
            end
         end
         S_ACCUM: begin
            // A fresh SOF abandons the partial frame without publishing it.
            if (sof) begin
               do_init = 1'b1;
            end else if (en) begin
               do_fold = 1'b1;
               if (eof) state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            // Always exactly one cycle so oValid lands a fixed two edges after EOF.
            o_valid_d = 1'b1;
            o_found_d = found;
            if (found) begin
               o_row_d = {bot_v, top_v};
               o_col_d = {rgt_v, lft_v};
            end
            if (sof) begin
               state_d = S_ACCUM;
               do_init = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The SOF pixel itself is part of the new frame.
      if (do_init) do_fold = 1'b1;

      rmin_b = do_init ? 10'h3FF : rmin_q;
      rmax_b = do_init ? 10'd0   : rmax_q;
      cmin_b = do_init ? 10'h3FF : cmin_q;
      cmax_b = do_init ? 10'd0   : cmax_q;
      cnt_b  = do_init ? 19'd0   : cnt_q;

      if (do_fold) begin
         rmin_d = rmin_b;
         rmax_d = rmax_b;
         cmin_d = cmin_b;
         cmax_d = cmax_b;
         cnt_d  = cnt_b;
         if (fg) begin
            if (Row < rmin_b) rmin_d = Row;
            if (Row > rmax_b) rmax_d = Row;
            if (Col < cmin_b) cmin_d = Col;
            if (Col > cmax_b) cmax_d = Col;
            cnt_d = (&cnt_b) ? cnt_b : cnt_b + 19'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         rmin_q    <= 10'h3FF;
         rmax_q    <= 10'd0;
         cmin_q    <= 10'h3FF;
         cmax_q    <= 10'd0;
         cnt_q     <= 19'd0;
         o_row_q   <= 20'd0;
         o_col_q   <= 20'd0;
         o_valid_q <= 1'b0;
         o_found_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rmin_q    <= rmin_d;
         rmax_q    <= rmax_d;
         cmin_q    <= cmin_d;
         cmax_q    <= cmax_d;
         cnt_q     <= cnt_d;
         o_row_q   <= o_row_d;
         o_col_q   <= o_col_d;
         o_valid_q <= o_valid_d;
         o_found_q <= o_found_d;
      end
   end

   assign oRow   = o_row_q;
   assign oCol   = o_col_q;
   assign oValid = o_valid_q;
   assign oFound = o_found_q;

endmodule

// File: tb/tb_bbox_detect.sv
// Directed bench for bbox_detect. Frames are sent sparsely: the SOF pixel,
// the interesting pixels, and the EOF pixel. Expected results are
// hand-computed and queued when EOF is driven; a negedge monitor pops one
// entry per oValid pulse and also checks the EOF-to-oValid latency.

module tb_bbox_detect;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [9:0]  Row, Col, iBW;
   logic [19:0] oRow, oCol;
   logic        oValid, oFound;

   bbox_detect dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .Row    (Row),
      .Col    (Col),
      .iBW    (iBW),
      .oRow   (oRow),
      .oCol   (oCol),
      .oValid (oValid),
      .oFound (oFound)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        found;
      logic [19:0] row;
      logic [19:0] col;
      int          due;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          neg_cnt = 0;
   bit          gaps = 0;
   logic [19:0] hrow = 20'd0;
   logic [19:0] hcol = 20'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      neg_cnt++;
      if (oValid) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ovalid: got oValid=1 expected 0 at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            chk("latency", neg_cnt, e.due);
            chk("oFound", {31'd0, oFound}, {31'd0, e.found});
            chk("oRow", {12'd0, oRow}, {12'd0, e.row});
            chk("oCol", {12'd0, oCol}, {12'd0, e.col});
         end
      end else if (sb_q.size() > 0 && neg_cnt > sb_q[0].due) begin
         n_vec++;
         n_err++;
         $display("FAIL missing_ovalid: got no pulse expected one by negedge %0d", sb_q[0].due);
         void'(sb_q.pop_front());
      end
   end

   task automatic pix(input int r, input int c, input logic fgp);
      if (gaps) begin
         while ($urandom_range(0, 99) < 30) begin
            @(posedge clk); #1;
            en  = 1'b0;
            Row = 10'($urandom);
            Col = 10'($urandom);
            iBW = 10'd0;
         end
      end
      @(posedge clk); #1;
      en  = 1'b1;
      Row = 10'(r);
      Col = 10'(c);
      iBW = fgp ? 10'd0 : 10'h3FF;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         en = 1'b0;
      end
   endtask

   task automatic block(input int r0, input int r1, input int c0, input int c1);
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++)
            pix(r, c, 1'b1);
   endtask

   task automatic eof(input logic fgp, input logic found, input logic [9:0] bot,
                      input logic [9:0] top, input logic [9:0] rgt, input logic [9:0] lft);
      exp_t e;
      pix(479, 639, fgp);
      if (found) begin
         hrow = {bot, top};
         hcol = {rgt, lft};
      end
      e.found = found;
      e.row   = hrow;
      e.col   = hcol;
      e.due   = neg_cnt + 3;
      sb_q.push_back(e);
   endtask

   task automatic chk_outs(input string tag, input logic found);
      @(negedge clk);
      chk({tag, "_oRow"}, {12'd0, oRow}, {12'd0, hrow});
      chk({tag, "_oCol"}, {12'd0, oCol}, {12'd0, hcol});
      chk({tag, "_oFound"}, {31'd0, oFound}, {31'd0, found});
      chk({tag, "_oValid"}, {31'd0, oValid}, 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b0;
      Row = 10'd0;
      Col = 10'd0;
      iBW = 10'h3FF;
      repeat (3) @(posedge clk);
      chk_outs("reset", 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      idle(3);

      // 1: solid block
      pix(0, 0, 1'b0);
      block(100, 149, 200, 259);
      eof(1'b0, 1'b1, 10'd153, 10'd96, 10'd263, 10'd196);
      idle(20);
      chk_outs("stable1", 1'b1);

      // 2: all white, result held
      pix(0, 0, 1'b0);
      for (int c = 0; c < 5; c++) pix(240, 300 + c, 1'b0);
      eof(1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
      idle(6);

      // 3: clamps at all four edges, SOF and EOF pixels both foreground
      block(0, 9, 0, 9);
      eof(1'b1, 1'b1, 10'd479, 10'd0, 10'd635, 10'd1);
      idle(6);

      // 4a: exactly MIN_PIX pixels, then 4b starts with SOF during LATCH
      pix(0, 0, 1'b0);
      for (int c = 300; c <= 315; c++) pix(200, c, 1'b1);
      eof(1'b0, 1'b1, 10'd204, 10'd196, 10'd319, 10'd296);
      pix(0, 0, 1'b0);
      for (int c = 10; c <= 17; c++) pix(10, c, 1'b1);
      eof(1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
      idle(6);

      // 5: SOF reinjected mid-frame discards the partial frame
      pix(0, 0, 1'b0);
      block(300, 309, 50, 59);
      pix(0, 0, 1'b0);
      block(100, 149, 200, 259);
      eof(1'b0, 1'b1, 10'd153, 10'd96, 10'd263, 10'd196);
      idle(6);

      // 6: reset mid-frame, tail of aborted frame ignored, then a full frame
      pix(0, 0, 1'b0);
      block(150, 200, 10, 20);
      @(posedge clk); #1;
      rst = 1'b0;
      en  = 1'b0;
      hrow = 20'd0;
      hcol = 20'd0;
      chk_outs("in_reset", 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      chk_outs("post_reset", 1'b0);
      block(201, 250, 10, 20);
      pix(479, 639, 1'b0);
      idle(8);
      chk_outs("aborted", 1'b0);
      pix(0, 0, 1'b0);
      block(20, 39, 30, 49);
      eof(1'b0, 1'b1, 10'd43, 10'd16, 10'd53, 10'd26);
      idle(6);

      // 7: first frame again with random en gaps
      gaps = 1'b1;
      pix(0, 0, 1'b0);
      block(100, 149, 200, 259);
      eof(1'b0, 1'b1, 10'd153, 10'd96, 10'd263, 10'd196);
      gaps = 1'b0;
      idle(6);

      for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(posedge clk);
      chk("queue_drained", sb_q.size(), 32'd0);
      chk_outs("final", 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
